// File: rtl/bh_pkg.sv
// bh_pkg -- definitions shared by the Bluetooth UART blocks (bh_send, bh_recv).
//
// Contents:
//   DATA_W  : payload width of one serial frame (8 bits)
//   state_t : receiver/transmitter FSM state encoding
//
// Configuration macro: BH_RECV_PARITY_EN
//   When defined, the PARITY state exists (even parity bit after the data).
//   When undefined, the PARITY state is absent from the encoding.
package bh_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef BH_RECV_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/bh_baud_cnt.sv
// bh_baud_cnt -- bit-period counter that marks the middle of each serial bit.
//
// The counter runs 0 .. BPS_CNT-1 and wraps, so once a frame is under way a
// mid-bit tick arrives every BPS_CNT cycles without re-arming. Holding clear
// parks the counter at 0; the first tick then comes BPS_CNT/2 cycles after
// clear is released.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   clear       : synchronous clear of the counter (has priority over enable)
//   enable      : count while high
//   sample_tick : one-cycle pulse at the mid-bit sample point
module bh_baud_cnt #(
    parameter int BPS_CNT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic sample_tick
);

    localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(BPS_CNT / 2 - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sample_tick = enable && !clear && (cnt == MID_CNT);

endmodule

// File: rtl/bh_recv.sv
// bh_recv -- UART receiver for the Bluetooth module link (8 data bits,
// LSB first, one stop bit, optional even parity).
//
// Ports:
//   sys_clk       : system clock, rising edge
//   sys_rst_n     : asynchronous active-low reset
//   uart_rxd      : serial input, asynchronous, idles high
//   rx_data       : last correctly received byte
//   rx_valid      : one-cycle pulse, rx_data has just been updated
//   rx_frame_err  : one-cycle pulse, stop bit sampled low
//   rx_parity_err : one-cycle pulse, parity mismatch (0 without parity)
//   rx_busy       : high from accepted start edge until back in IDLE
//   state         : current FSM state, exported for debug/observation
//
// Configuration macro: BH_RECV_PARITY_EN (even parity bit after the data).
//
// Handshake: rx_valid is a strobe with no ready; the consumer must capture
// rx_data in the cycle rx_valid is high. rx_valid, rx_frame_err and
// rx_parity_err are mutually exclusive and each lasts exactly one cycle.
module bh_recv
    import bh_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    output logic              rx_busy,
    output state_t            state
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int BIT_W   = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    // Two-flop synchronizer plus one history flop for edge detection. All
    // reset to the idle level so reset release never looks like a start edge.
    logic sync1, sync2, rxd_d;
    logic rxd, start_edge, tick;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            rxd_d <= sync2;
        end
    end

    assign rxd        = sync2;
    // Requires a real 1->0 transition: a line held low after a framing
    // error does not retrigger.
    assign start_edge = rxd_d & ~rxd;

    bh_baud_cnt #(.BPS_CNT(BPS_CNT)) u_baud (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .clear       (state == IDLE),
        .enable      (state != IDLE),
        .sample_tick (tick)
    );

    state_t            state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt, data_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              valid_nxt, ferr_nxt;
`ifdef BH_RECV_PARITY_EN
    logic              par_bad, par_bad_nxt, perr_nxt;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            shift        <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef BH_RECV_PARITY_EN
            par_bad       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            shift        <= shift_nxt;
            bit_cnt      <= bit_cnt_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
`ifdef BH_RECV_PARITY_EN
            par_bad       <= par_bad_nxt;
            rx_parity_err <= perr_nxt;
`endif
        end
    end

`ifndef BH_RECV_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        data_nxt    = rx_data;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef BH_RECV_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt   = START;
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
`ifdef BH_RECV_PARITY_EN
                    par_bad_nxt = 1'b0;
`endif
                end
            end
            START: begin
                // Line back high at mid start bit means it was a glitch.
                if (tick) begin
                    state_nxt = rxd ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = {rxd, shift[DATA_W-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
`ifdef BH_RECV_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef BH_RECV_PARITY_EN
            PARITY: begin
                if (tick) begin
                    // Even parity: data bits plus parity bit XOR to 0.
                    par_bad_nxt = rxd ^ (^shift);
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    if (!rxd) begin
                        ferr_nxt = 1'b1;
`ifdef BH_RECV_PARITY_EN
                    end else if (par_bad) begin
                        perr_nxt = 1'b1;
`endif
                    end else begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_bh_recv.sv
// tb_bh_recv -- directed bench for bh_recv at CLK_FREQ=40, UART_BPS=4
// (10 clocks per bit, 4 ns clock). Parity cases are included when
// BH_RECV_PARITY_EN is defined.
module tb_bh_recv;
    import bh_pkg::*;

    localparam int BPS = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err, rx_busy;
    state_t     dbg_state;

    bh_recv #(.CLK_FREQ(40), .UART_BPS(4)) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .uart_rxd      (uart_rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_busy       (rx_busy),
        .state         (dbg_state)
    );

    // clock / reset
    always #2 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];
    int valid_pulses = 0, valid_cycles = 0;
    int ferr_pulses  = 0, ferr_cycles  = 0;
    int perr_pulses  = 0, perr_cycles  = 0;
    int overlap      = 0;
    logic valid_q = 1'b0, ferr_q = 1'b0, perr_q = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cycles++;
            if (!valid_q) begin
                valid_pulses++;
                if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (rx_frame_err) begin
            ferr_cycles++;
            if (!ferr_q) ferr_pulses++;
        end
        if (rx_parity_err) begin
            perr_cycles++;
            if (!perr_q) perr_pulses++;
        end
        if (32'(rx_valid) + 32'(rx_frame_err) + 32'(rx_parity_err) > 1) overlap++;
        valid_q = rx_valid;
        ferr_q  = rx_frame_err;
        perr_q  = rx_parity_err;
    end

    // drivers
    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (BPS) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        uart_rxd = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef BH_RECV_PARITY_EN
        drive_bit(par_bit);
`else
        if (par_bit === 1'bx) uart_rxd = 1'b1;
`endif
        drive_bit(stop_bit);
    endtask

    int v0, f0, p0, vc0, fc0;

    initial begin
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_parity_err", 32'(rx_parity_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        idle(5);

        // good frame 0x55
        v0 = valid_pulses; vc0 = valid_cycles;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b1);
        idle(3);
        check("f55_pulses", 32'(valid_pulses - v0), 32'd1);
        check("f55_width", 32'(valid_cycles - vc0), 32'd1);
        check("f55_busy", 32'(rx_busy), 32'd0);
        check("f55_data", 32'(rx_data), 32'h55);

        // frame 0x3C with low stop bit, line then held low
        v0 = valid_pulses; f0 = ferr_pulses; fc0 = ferr_cycles;
        send_frame(8'h3C, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        repeat (25) @(negedge clk);
        check("ferr_pulses", 32'(ferr_pulses - f0), 32'd1);
        check("ferr_width", 32'(ferr_cycles - fc0), 32'd1);
        check("ferr_no_valid", 32'(valid_pulses - v0), 32'd0);
        check("ferr_data_kept", 32'(rx_data), 32'h55);
        check("ferr_low_no_start", 32'(rx_busy), 32'd0);
        idle(15);

        // 3-cycle glitch, then 0xA3
        v0 = valid_pulses; f0 = ferr_pulses; p0 = perr_pulses;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(4);
        check("glitch_busy_seen", 32'(rx_busy), 32'd1);
        idle(20);
        check("glitch_no_valid", 32'(valid_pulses - v0), 32'd0);
        check("glitch_no_ferr", 32'(ferr_pulses - f0), 32'd0);
        check("glitch_no_perr", 32'(perr_pulses - p0), 32'd0);
        check("glitch_state", 32'(dbg_state), 32'(IDLE));
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b0, 1'b1);
        idle(3);
        check("fA3_pulses", 32'(valid_pulses - v0), 32'd1);
        check("fA3_data", 32'(rx_data), 32'hA3);

        // reset during bit 4 of 0xFF
        v0 = valid_pulses; f0 = ferr_pulses;
        uart_rxd = 1'b0;
        repeat (BPS) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4 * BPS + 5) @(negedge clk);
        check("mid_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(rx_data), 32'h00);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_ferr", 32'(rx_frame_err), 32'd0);
        check("mid_rst_perr", 32'(rx_parity_err), 32'd0);
        check("mid_rst_busy", 32'(rx_busy), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        check("mid_no_valid", 32'(valid_pulses - v0), 32'd0);
        check("mid_no_ferr", 32'(ferr_pulses - f0), 32'd0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(3);
        check("f0F_data", 32'(rx_data), 32'h0F);

        // back-to-back 0x00, 0xFF with a 1-bit gap
        v0 = valid_pulses;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b0, 1'b1);
        idle(BPS);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(3);
        check("b2b_pulses", 32'(valid_pulses - v0), 32'd2);
        check("b2b_last_data", 32'(rx_data), 32'hFF);

`ifdef BH_RECV_PARITY_EN
        // 0x01 needs parity 1 for even parity
        v0 = valid_pulses; p0 = perr_pulses;
        send_frame(8'h01, 1'b0, 1'b1);
        idle(3);
        check("par_bad_perr", 32'(perr_pulses - p0), 32'd1);
        check("par_bad_no_valid", 32'(valid_pulses - v0), 32'd0);
        check("par_bad_data_kept", 32'(rx_data), 32'hFF);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b1);
        idle(3);
        check("par_ok_valid", 32'(valid_pulses - v0), 32'd1);
        check("par_ok_data", 32'(rx_data), 32'h01);
        check("perr_width", 32'(perr_cycles), 32'(perr_pulses));
`else
        check("perr_never", 32'(perr_cycles), 32'd0);
`endif

        check("valid_width_all", 32'(valid_cycles), 32'(valid_pulses));
        check("pulse_overlap", 32'(overlap), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bh_recv.md
BH_RECV -- requirements
Module: bh_recv

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, serial baud rate.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port uart_rxd  input  1  serial line from the Bluetooth module; asynchronous to sys_clk; idles high.
REQ-006 SHALL have port rx_data  output  8  last correctly received byte.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port rx_parity_err  output  1  one-cycle pulse: parity mismatch.
REQ-010 SHALL have port rx_busy  output  1  high from accepted start edge until return to IDLE.

Function
REQ-011 SHALL define BPS_CNT = CLK_FREQ/UART_BPS (integer divide); sample point = BPS_CNT/2.
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer; both flops reset to 1.
REQ-013 SHALL detect a start edge as synchronized line 1 -> 0, and only in IDLE.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL move IDLE -> START on a start edge, clearing the baud counter and asserting rx_busy.
REQ-016 SHALL resample the line in START when the counter reaches BPS_CNT/2-1:
- high: glitch; go to IDLE with no output pulse;
- low: go to DATA and restart the bit timing.
REQ-017 SHALL sample DATA bits every BPS_CNT cycles at mid-bit, shifting LSB first, bit counter 0..7.
REQ-018 SHALL leave DATA after 8 bits: to PARITY if the macro is defined, otherwise to STOP.
REQ-019 SHALL sample the stop bit at mid-bit in STOP:
- high: load rx_data from the shift register and pulse rx_valid in the next cycle;
- low: pulse rx_frame_err and keep rx_data unchanged.
REQ-020 SHALL return to IDLE in the cycle after the stop sample; rx_busy deasserts in that cycle.
REQ-021 SHALL NOT start a new frame while the line stays low after a framing error; a new frame requires a fresh 1 -> 0 edge.
REQ-022 SHALL assert rx_valid exactly once per good frame; rx_valid, rx_frame_err and rx_parity_err SHALL never be high together.
REQ-023 SHALL have the baud counter width ceil(log2(BPS_CNT)) and SHALL never wrap within a bit.

Reset
REQ-024 SHALL on sys_rst_n low, at any time including mid-frame, go to IDLE and set:
- rx_data = 0x00;
- rx_valid, rx_frame_err, rx_parity_err, rx_busy = 0;
- counters and shift register = 0.
REQ-025 SHALL not produce any pulse for a frame interrupted by reset.

Configuration
REQ-026 SHALL use macro BH_RECV_PARITY_EN.
- Defined: even parity bit after the data bits, sampled at mid-bit in PARITY. On mismatch, rx_parity_err pulses together with the stop-bit decision, rx_valid stays low and rx_data is unchanged.
- Undefined: no PARITY state; rx_parity_err is tied to 0.

Structure
REQ-027 SHALL put the FSM state enum and the DATA_W=8 constant in shared package bh_pkg, used by bh_send and bh_recv.
REQ-028 SHALL implement baud timing in sub-module bh_baud_cnt, with inputs clear and enable and output sample_tick at mid-bit.

Verification (CLK_FREQ=40, UART_BPS=4, BPS_CNT=10, clock period 4 ns)
REQ-029 SHALL test: frame 0x55 with a good stop bit -> rx_data=0x55, rx_valid high for exactly 1 cycle, rx_busy low afterwards.
REQ-030 SHALL test: a 3-cycle low glitch on uart_rxd -> no rx_valid and no error pulse, FSM back in IDLE; next frame 0xA3 received correctly.
REQ-031 SHALL test: frame 0x3C with stop bit 0 -> rx_frame_err 1-cycle pulse, rx_data keeps 0x55, no rx_valid.
REQ-032 SHALL test: reset asserted during bit 4 of frame 0xFF -> all outputs 0 immediately; next frame 0x0F -> rx_data=0x0F.
REQ-033 SHALL test: back-to-back frames 0x00 then 0xFF with a 1-bit idle gap between them -> two rx_valid pulses with the correct data each.
REQ-034 SHALL test with BH_RECV_PARITY_EN defined: 0x01 with parity bit 0 -> rx_parity_err pulse and no rx_valid; 0x01 with parity bit 1 -> rx_valid and rx_data=0x01.
